move_scheduler: RTL and testbench

Sequences all motion of the falling tetromino. Collects user move requests and the gravity tick, arbitrates them into a single command stream, and hands one command at a time to the playfield collision/move datapath. It returns `user_input` and `hard_drop` pulses to GameStatesFSM, which uses them for lock-delay reset and piece lock. It sits between the input debouncers / gravity timing and the falling-piece datapath.

---
 rtl/move_scheduler_pkg.sv | 58 +++++
 rtl/move_scheduler_counter.sv | 24 ++
 rtl/move_scheduler.sv | 139 +++++++++++++
 tb/tb_move_scheduler.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/move_scheduler_pkg.sv
// move_scheduler_pkg: command codes, scheduler states, gravity periods and flag helpers for the falling-piece scheduler.
package move_scheduler_pkg;

   typedef enum logic [2:0] {
      MV_NONE, MV_DOWN, MV_LEFT, MV_RIGHT, MV_ROT_CW, MV_ROT_CCW, MV_HARD
   } move_cmd_t;

   typedef enum logic [1:0] {
      S_DISABLED, S_READY, S_ISSUE, S_WAIT_RESP
   } move_sched_state_t;

   localparam int NF      = 6;
   localparam int F_GRAV  = 0;
   localparam int F_RIGHT = 1;
   localparam int F_LEFT  = 2;
   localparam int F_CCW   = 3;
   localparam int F_CW    = 4;
   localparam int F_HARD  = 5;

   // Periods are frame counts per row scaled by FRAME_CLKS; retune FRAME_CLKS for the real clock.
   localparam logic [31:0] FRAME_CLKS = 32'd64;
   localparam logic [31:0] GRAVITY_TABLE [32] = '{
      32'd48 * FRAME_CLKS, 32'd43 * FRAME_CLKS, 32'd38 * FRAME_CLKS, 32'd33 * FRAME_CLKS,
      32'd28 * FRAME_CLKS, 32'd23 * FRAME_CLKS, 32'd18 * FRAME_CLKS, 32'd13 * FRAME_CLKS,
      32'd8  * FRAME_CLKS, 32'd6  * FRAME_CLKS, 32'd5  * FRAME_CLKS, 32'd5  * FRAME_CLKS,
      32'd5  * FRAME_CLKS, 32'd4  * FRAME_CLKS, 32'd4  * FRAME_CLKS, 32'd4  * FRAME_CLKS,
      32'd3  * FRAME_CLKS, 32'd3  * FRAME_CLKS, 32'd3  * FRAME_CLKS, 32'd2  * FRAME_CLKS,
      32'd2  * FRAME_CLKS, 32'd2  * FRAME_CLKS, 32'd2  * FRAME_CLKS, 32'd2  * FRAME_CLKS,
      32'd2  * FRAME_CLKS, 32'd2  * FRAME_CLKS, 32'd2  * FRAME_CLKS, 32'd2  * FRAME_CLKS,
      32'd2  * FRAME_CLKS, 32'd1  * FRAME_CLKS, 32'd1  * FRAME_CLKS, 32'd1  * FRAME_CLKS
   };

   function automatic logic [NF-1:0] cmd_flag(input move_cmd_t c);
      logic [NF-1:0] f;
      f = '0;
      f[F_GRAV]  = c == MV_DOWN;
      f[F_RIGHT] = c == MV_RIGHT;
      f[F_LEFT]  = c == MV_LEFT;
      f[F_CCW]   = c == MV_ROT_CCW;
      f[F_CW]    = c == MV_ROT_CW;
      f[F_HARD]  = c == MV_HARD;
      return f;
   endfunction

   function automatic move_cmd_t sel_cmd(input logic [NF-1:0] p);
      return p[F_HARD]  ? MV_HARD    :
             p[F_CW]    ? MV_ROT_CW  :
             p[F_CCW]   ? MV_ROT_CCW :
             p[F_LEFT]  ? MV_LEFT    :
             p[F_RIGHT] ? MV_RIGHT   :
             p[F_GRAV]  ? MV_DOWN    : MV_NONE;
   endfunction

   function automatic logic is_user(input move_cmd_t c);
      return c inside {MV_LEFT, MV_RIGHT, MV_ROT_CW, MV_ROT_CCW};
   endfunction

endpackage

// File: rtl/move_scheduler_counter.sv
// move_scheduler_counter: loadable down-counter that holds at zero and flags it.
module move_scheduler_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_l,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = load ? load_val : (en && count_q != '0) ? count_q - W'(1) : count_q;
      zero    = count_q == '0;
   end

   always_ff @(posedge clk or negedge rst_l)
      if (!rst_l) count_q <= '0;
      else        count_q <= count_d;

endmodule

// File: rtl/move_scheduler.sv
// move_scheduler: arbitrates user moves and gravity into one command stream for the playfield datapath.
module move_scheduler
   import move_scheduler_pkg::*;
#(
   parameter int          CNT_WIDTH        = 32,
   parameter logic [31:0] SOFT_DROP_PERIOD = 32'd2_500_000
) (
   input  logic      clk,
   input  logic      rst_l,
   input  logic      piece_active,
   input  logic [4:0] level,
   input  logic      req_left,
   input  logic      req_right,
   input  logic      req_rot_cw,
   input  logic      req_rot_ccw,
   input  logic      req_hard,
   input  logic      soft_drop,
   output logic      cmd_valid,
   output move_cmd_t cmd,
   input  logic      cmd_ready,
   input  logic      cmd_done,
   input  logic      cmd_ok,
   output logic      user_input,
   output logic      hard_drop,
   output logic      busy
);

   move_sched_state_t state_q, state_d;
   move_cmd_t         cmd_q, cmd_d, inflight_q, inflight_d;
   logic [NF-1:0]     pend_q, pend_d, pend_set, req, acc_clr;
   logic              cmd_valid_q, cmd_valid_d, user_input_q, user_input_d;
   logic              hard_drop_q, hard_drop_d, busy_q, busy_d, soft_drop_q, soft_drop_d;
   logic              active, entry, soft_rise, expiry, grav_load, grav_zero, hard_done;
   logic [31:0]       tbl, reload;
   logic [CNT_WIDTH-1:0] grav_val;

   // Reloads use period-1 because the reload cycle itself counts toward the next period.
   always_comb begin
      active      = state_q != S_DISABLED;
      entry       = !active && piece_active;
      tbl         = GRAVITY_TABLE[level];
      reload      = (soft_drop && SOFT_DROP_PERIOD < tbl) ? SOFT_DROP_PERIOD : tbl;
      soft_drop_d = soft_drop;
      soft_rise   = active && soft_drop && !soft_drop_q;
      expiry      = active && grav_zero;
      grav_load   = entry || expiry || soft_rise;
      grav_val    = CNT_WIDTH'(entry ? tbl : (reload == '0) ? '0 : reload - 32'd1);
   end

   move_scheduler_counter #(.W(CNT_WIDTH)) gravity_counter (
      .clk      (clk),
      .rst_l    (rst_l),
      .load     (grav_load),
      .en       (active),
      .load_val (grav_val),
      .zero     (grav_zero)
   );

   always_comb begin
      req       = {req_hard, req_rot_cw, req_rot_ccw, req_left, req_right, expiry || soft_rise};
      acc_clr   = (state_q == S_ISSUE && cmd_ready) ? cmd_flag(cmd_q) : '0;
      hard_done = state_q == S_WAIT_RESP && cmd_done && inflight_q == MV_HARD;
      pend_set  = (hard_done ? '0 : pend_q & ~acc_clr) | req;
      pend_d    = pend_set & ~{1'b0, {2{pend_set[F_CW] && pend_set[F_CCW]}},
                               {2{pend_set[F_LEFT] && pend_set[F_RIGHT]}}, 1'b0};
      state_d      = state_q;
      cmd_d        = cmd_q;
      cmd_valid_d  = cmd_valid_q;
      inflight_d   = inflight_q;
      user_input_d = 1'b0;
      hard_drop_d  = 1'b0;
      if (!piece_active) begin
         state_d     = S_DISABLED;
         cmd_valid_d = 1'b0;
         cmd_d       = MV_NONE;
         inflight_d  = MV_NONE;
         pend_d      = '0;
      end else begin
         case (state_q)
            S_DISABLED: begin
               state_d = S_READY;
               pend_d  = '0;
            end
            S_READY:
               if (|pend_d) begin
                  state_d     = S_ISSUE;
                  cmd_valid_d = 1'b1;
                  cmd_d       = sel_cmd(pend_d);
               end
            S_ISSUE:
               if (cmd_ready) begin
                  state_d     = S_WAIT_RESP;
                  cmd_valid_d = 1'b0;
                  cmd_d       = MV_NONE;
                  inflight_d  = cmd_q;
               end
            S_WAIT_RESP:
               if (cmd_done) begin
                  state_d      = S_READY;
                  inflight_d   = MV_NONE;
                  user_input_d = cmd_ok && is_user(inflight_q);
                  hard_drop_d  = inflight_q == MV_HARD;
               end
            default: state_d = S_DISABLED;
         endcase
      end
      busy_d = state_d inside {S_ISSUE, S_WAIT_RESP};
   end

   always_ff @(posedge clk or negedge rst_l)
      if (!rst_l) begin
         state_q      <= S_DISABLED;
         cmd_q        <= MV_NONE;
         inflight_q   <= MV_NONE;
         pend_q       <= '0;
         cmd_valid_q  <= 1'b0;
         user_input_q <= 1'b0;
         hard_drop_q  <= 1'b0;
         busy_q       <= 1'b0;
         soft_drop_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cmd_q        <= cmd_d;
         inflight_q   <= inflight_d;
         pend_q       <= pend_d;
         cmd_valid_q  <= cmd_valid_d;
         user_input_q <= user_input_d;
         hard_drop_q  <= hard_drop_d;
         busy_q       <= busy_d;
         soft_drop_q  <= soft_drop_d;
      end

   assign cmd_valid  = cmd_valid_q;
   assign cmd        = cmd_q;
   assign user_input = user_input_q;
   assign hard_drop  = hard_drop_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_move_scheduler.sv
// tb_move_scheduler: directed checks of arbitration, gravity timing, completion pulses and reset.
module tb_move_scheduler;
   import move_scheduler_pkg::*;

   logic      clk = 1'b0;
   logic      rst_l = 1'b0;
   logic      piece_active = 1'b0;
   logic [4:0] level = '0;
   logic      req_left = 1'b0, req_right = 1'b0, req_rot_cw = 1'b0, req_rot_ccw = 1'b0, req_hard = 1'b0;
   logic      soft_drop = 1'b0;
   logic      cmd_valid;
   move_cmd_t cmd;
   logic      cmd_ready = 1'b0, cmd_done = 1'b0, cmd_ok = 1'b0;
   logic      user_input, hard_drop, busy;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int n, s0, s1;
   logic seen;

   always #5 clk = ~clk;

   move_scheduler #(.SOFT_DROP_PERIOD(32'd20)) dut (
      .clk          (clk),
      .rst_l        (rst_l),
      .piece_active (piece_active),
      .level        (level),
      .req_left     (req_left),
      .req_right    (req_right),
      .req_rot_cw   (req_rot_cw),
      .req_rot_ccw  (req_rot_ccw),
      .req_hard     (req_hard),
      .soft_drop    (soft_drop),
      .cmd_valid    (cmd_valid),
      .cmd          (cmd),
      .cmd_ready    (cmd_ready),
      .cmd_done     (cmd_done),
      .cmd_ok       (cmd_ok),
      .user_input   (user_input),
      .hard_drop    (hard_drop),
      .busy         (busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic restart();
      piece_active = 1'b0;
      tick();
      piece_active = 1'b1;
      tick();
   endtask

   initial begin
      tick();
      tick();
      chk("rst_valid", cmd_valid, 0);
      chk("rst_cmd", cmd, MV_NONE);
      chk("rst_user", user_input, 0);
      chk("rst_hard", hard_drop, 0);
      chk("rst_busy", busy, 0);

      // Level 0 gravity: first MV_DOWN 3072+1 cycles after entering READY
      rst_l = 1'b1;
      piece_active = 1'b1;
      tick();
      n = 0;
      for (int i = 1; i <= 4000; i++) begin
         tick();
         if (cmd_valid) begin
            n = i;
            break;
         end
      end
      chk("grav_latency", n, 3073);
      chk("grav_cmd", cmd, MV_DOWN);
      chk("grav_busy", busy, 1);
      cmd_ready = 1'b1;
      tick();
      chk("grav_acc_valid", cmd_valid, 0);
      chk("grav_acc_cmd", cmd, MV_NONE);
      cmd_ready = 1'b0; cmd_done = 1'b1; cmd_ok = 1'b1;
      tick();
      chk("grav_no_user", user_input, 0);
      chk("grav_idle_busy", busy, 0);
      cmd_done = 1'b0;

      // Left move accepted, ok=1 then ok=0
      restart();
      req_left = 1'b1; cmd_ready = 1'b1;
      tick();
      chk("left_valid", cmd_valid, 1);
      chk("left_cmd", cmd, MV_LEFT);
      req_left = 1'b0;
      tick();
      chk("left_acc_valid", cmd_valid, 0);
      chk("left_acc_cmd", cmd, MV_NONE);
      cmd_ready = 1'b0; cmd_done = 1'b1; cmd_ok = 1'b1;
      tick();
      chk("left_user", user_input, 1);
      cmd_done = 1'b0;
      tick();
      chk("left_user_once", user_input, 0);
      req_left = 1'b1; cmd_ready = 1'b1;
      tick();
      req_left = 1'b0;
      tick();
      cmd_ready = 1'b0; cmd_done = 1'b1; cmd_ok = 1'b0;
      tick();
      chk("left_blocked_user", user_input, 0);
      cmd_done = 1'b0;

      // Request during its own accept re-sets the flag
      req_left = 1'b1;
      tick();
      cmd_ready = 1'b1;
      tick();
      req_left = 1'b0; cmd_ready = 1'b0; cmd_done = 1'b1; cmd_ok = 1'b1;
      tick();
      cmd_done = 1'b0;
      tick();
      chk("reset_wins_valid", cmd_valid, 1);
      chk("reset_wins_cmd", cmd, MV_LEFT);
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0; cmd_done = 1'b1; cmd_ok = 1'b0;
      tick();
      cmd_done = 1'b0;

      // Opposing requests cancel; rotation outranks left
      restart();
      req_left = 1'b1; req_right = 1'b1;
      tick();
      req_left = 1'b0; req_right = 1'b0;
      seen = cmd_valid;
      for (int i = 0; i < 4; i++) begin
         tick();
         seen = seen | cmd_valid;
      end
      chk("lr_cancel", seen, 0);
      req_rot_cw = 1'b1; req_left = 1'b1;
      tick();
      chk("prio_first", cmd, MV_ROT_CW);
      req_rot_cw = 1'b0; req_left = 1'b0; cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0; cmd_done = 1'b1; cmd_ok = 1'b1;
      tick();
      chk("rot_user", user_input, 1);
      cmd_done = 1'b0;
      tick();
      chk("prio_second_valid", cmd_valid, 1);
      chk("prio_second", cmd, MV_LEFT);
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0; cmd_done = 1'b1; cmd_ok = 1'b1;
      tick();
      cmd_done = 1'b0;

      // Hard drop overrides pending left/rot/grav and clears everything
      restart();
      req_right = 1'b1;
      tick();
      chk("hard_pre_cmd", cmd, MV_RIGHT);
      req_right = 1'b0; cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0; req_left = 1'b1; req_rot_ccw = 1'b1; soft_drop = 1'b1;
      tick();
      req_left = 1'b0; req_rot_ccw = 1'b0; soft_drop = 1'b0; req_hard = 1'b1;
      tick();
      req_hard = 1'b0; cmd_done = 1'b1; cmd_ok = 1'b0;
      tick();
      chk("right_blocked_user", user_input, 0);
      cmd_done = 1'b0;
      tick();
      chk("hard_cmd", cmd, MV_HARD);
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0; cmd_done = 1'b1; cmd_ok = 1'b0;
      tick();
      chk("hard_pulse", hard_drop, 1);
      chk("hard_no_user", user_input, 0);
      cmd_done = 1'b0;
      tick();
      chk("hard_pulse_once", hard_drop, 0);
      seen = cmd_valid;
      for (int i = 0; i < 3; i++) begin
         tick();
         seen = seen | cmd_valid;
      end
      chk("hard_flags_clear", seen, 0);

      // Soft drop: immediate MV_DOWN then one every 20 cycles
      restart();
      soft_drop = 1'b1;
      tick();
      s0 = cyc;
      chk("soft_first_valid", cmd_valid, 1);
      chk("soft_first_cmd", cmd, MV_DOWN);
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0; cmd_done = 1'b1; cmd_ok = 1'b1;
      tick();
      chk("soft_no_user", user_input, 0);
      cmd_done = 1'b0;
      for (int i = 0; i < 100 && !cmd_valid; i++) tick();
      chk("soft_valid2", cmd_valid, 1);
      chk("soft_period1", cyc - s0, 20);
      s1 = cyc;
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0; cmd_done = 1'b1; cmd_ok = 1'b1;
      tick();
      cmd_done = 1'b0;
      for (int i = 0; i < 100 && !cmd_valid; i++) tick();
      chk("soft_valid3", cmd_valid, 1);
      chk("soft_period2", cyc - s1, 20);
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0; cmd_done = 1'b1; soft_drop = 1'b0;
      tick();
      cmd_done = 1'b0;

      // piece_active dropped in WAIT_RESP; late cmd_done ignored
      restart();
      req_left = 1'b1;
      tick();
      req_left = 1'b0; cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      chk("wait_busy", busy, 1);
      piece_active = 1'b0;
      tick();
      chk("drop_busy", busy, 0);
      chk("drop_valid", cmd_valid, 0);
      cmd_done = 1'b1; cmd_ok = 1'b1;
      tick();
      chk("drop_no_user", user_input, 0);
      chk("drop_no_hard", hard_drop, 0);
      cmd_done = 1'b0; req_left = 1'b1;
      tick();
      req_left = 1'b0; piece_active = 1'b1;
      tick();
      tick();
      chk("disabled_req_dropped", cmd_valid, 0);

      // Asynchronous reset in the middle of ISSUE
      req_rot_cw = 1'b1;
      tick();
      req_rot_cw = 1'b0;
      chk("pre_rst_valid", cmd_valid, 1);
      #2;
      rst_l = 1'b0;
      #1;
      chk("arst_valid", cmd_valid, 0);
      chk("arst_cmd", cmd, MV_NONE);
      chk("arst_busy", busy, 0);
      chk("arst_user", user_input, 0);
      chk("arst_hard", hard_drop, 0);
      tick();
      rst_l = 1'b1;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
